mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, giving the request and memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, giving the load/store data width.
REQ-003 SHALL have port iClock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port iReset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port iReqValid, input, 1 bit: EXU request valid.
REQ-006 SHALL have port oReqReady, output, 1 bit: LSU accepts a request.
REQ-007 SHALL have port iReqWr, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port iReqFunc3, input, 3 bits: RISC-V funct3 size/sign code.
REQ-009 SHALL have port iReqAddr, input, ADDR_WIDTH bits: byte address.
REQ-010 SHALL have port iReqWrData, input, DATA_WIDTH bits: store data, low-aligned.
REQ-011 SHALL have port oRespValid, output, 1 bit: response valid.
REQ-012 SHALL have port iRespReady, input, 1 bit: WBU accepts the response.
REQ-013 SHALL have port oRespData, output, DATA_WIDTH bits: extended load result.
REQ-014 SHALL have port oRespErr, output, 1 bit: misaligned or illegal request.
REQ-015 SHALL have port oMemRdEn, output, 1 bit: memory read enable; the memory registers read data at this edge.
REQ-016 SHALL have port oMemRdAddrLoad, output, ADDR_WIDTH bits: 8-byte-aligned read address.
REQ-017 SHALL have port iMemRdDataLoad, input, DATA_WIDTH bits: read data, valid the cycle after oMemRdEn.
REQ-018 SHALL have ports oMemWrEn (output, 1 bit), oMemWrAddr (output, ADDR_WIDTH bits), oMemWrData (output, DATA_WIDTH bits) and oMemWrLen (output, 8 bits) for the memory write.

Function
REQ-019 SHALL implement FSM states IDLE, RD_REQ, RD_DATA, WR, RESP; oReqReady=1 only in IDLE.
REQ-020 SHALL latch all request fields on iReqValid&oReqReady.
REQ-021 SHALL, after accepting a request, go from IDLE to: RESP if the request is illegal; else RD_REQ for a load; else WR for a store.
REQ-022 SHALL treat the request as illegal when any of the following holds; oRespErr=1, no memory access:
- load funct3 = 111;
- store funct3[2] = 1;
- halfword addr[0] != 0;
- word addr[1:0] != 0;
- doubleword addr[2:0] != 0.
REQ-023 SHALL in RD_REQ drive oMemRdEn=1 and oMemRdAddrLoad = addr with bits [2:0] cleared, for exactly one cycle, then go to RD_DATA.
REQ-024 SHALL in RD_DATA shift iMemRdDataLoad right by addr[2:0]*8 and extend the result into the oRespData register:
- 000: LB, sign-extend 8 bits;
- 001: LH, sign-extend 16 bits;
- 010: LW, sign-extend 32 bits;
- 011: LD, no extension;
- 100: LBU, zero-extend 8 bits;
- 101: LHU, zero-extend 16 bits;
- 110: LWU, zero-extend 32 bits.
REQ-025 SHALL go from RD_DATA to RESP.
REQ-026 SHALL in WR, for exactly one cycle, drive oMemWrEn=1, oMemWrAddr = raw addr, oMemWrData = iReqWrData as latched, and oMemWrLen = 1/2/4/8 for funct3 00/01/10/11, then go to RESP.
REQ-027 SHALL hold oMemRdEn=0 and oMemWrEn=0 in every state not named for them; the address/data/len outputs are don't-care when their enable is 0.
REQ-028 SHALL set oRespData=0 for stores and errors.
REQ-029 SHALL in RESP hold oRespValid=1 with oRespData/oRespErr stable until iRespReady=1, then return to IDLE on that edge.
REQ-030 SHALL have latency from accept edge to oRespValid of 3 cycles for a load, 2 for a store and 1 for an error; one request is outstanding at a time; the next request is accepted no earlier than the cycle after the response handshake.
REQ-031 SHALL ignore iReqValid when not in IDLE.
REQ-032 SHALL register all outputs or decode them from the state only; there is no combinational path from iReq* or iRespReady to any output.

Reset
REQ-033 SHALL, while iReset=0 and regardless of the clock, immediately force:
- state = IDLE;
- oRespValid = 0, oRespErr = 0, oRespData = 0;
- oMemRdEn = 0, oMemWrEn = 0;
- latched request fields = 0.
REQ-034 SHALL, on reset asserted mid-operation, abort any in-flight access (including a WR-cycle write) and issue no response for it.
REQ-035 SHALL have oReqReady=0 while in reset and oReqReady=1 in the first cycle after reset deasserts.

Verification
REQ-036 SHALL be verified by: memory dword at 0x80000000 = 0x1122334455667788; LB at addr 0x80000007 -> oMemRdAddrLoad=0x80000000, oRespData=0x0000000000000011, 3 cycles after accept.
REQ-037 SHALL be verified by: same dword; LH at 0x80000006 -> 0x0000000000001122; the dword's byte 5 changed to 0x99; LBU at 0x80000005 -> 0x99; LB at 0x80000005 -> 0xFFFFFFFFFFFFFF99.
REQ-038 SHALL be verified by: SW addr 0x80000104, data 0xDEADBEEF -> one-cycle oMemWrEn, oMemWrLen=4, oMemWrAddr=0x80000104; oRespValid 2 cycles after accept, oRespData=0, oRespErr=0.
REQ-039 SHALL be verified by: LW at 0x80000002 -> oRespErr=1 one cycle after accept, with no oMemRdEn pulse; the same for store funct3=100.
REQ-040 SHALL be verified by: response with iRespReady held 0 for 5 cycles -> oRespValid/oRespData stable and oReqReady=0 throughout; a new iReqValid during the stall is not accepted.
REQ-041 SHALL be verified by: iReset pulled low during WR -> oMemWrEn drops with no clock edge, no response follows, and oReqReady=1 the first cycle after release.

Source files
------------

// File: rtl/mem_lsu_if.sv
// mem_lsu_if -- bundle of the load/store unit's handshake and memory buses.
//
// Request channel  : iReqValid/oReqReady, iReqWr, iReqFunc3, iReqAddr, iReqWrData
// Response channel : oRespValid/iRespReady, oRespData, oRespErr
// Memory read      : oMemRdEn, oMemRdAddrLoad, iMemRdDataLoad (data one cycle after enable)
// Memory write     : oMemWrEn, oMemWrAddr, oMemWrData, oMemWrLen (bytes)
//
// Modport slave is the LSU's view; modport master is the surrounding core/memory view.
interface mem_lsu_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  iReqValid;
    logic                  oReqReady;
    logic                  iReqWr;
    logic [2:0]            iReqFunc3;
    logic [ADDR_WIDTH-1:0] iReqAddr;
    logic [DATA_WIDTH-1:0] iReqWrData;

    logic                  oRespValid;
    logic                  iRespReady;
    logic [DATA_WIDTH-1:0] oRespData;
    logic                  oRespErr;

    logic                  oMemRdEn;
    logic [ADDR_WIDTH-1:0] oMemRdAddrLoad;
    logic [DATA_WIDTH-1:0] iMemRdDataLoad;

    logic                  oMemWrEn;
    logic [ADDR_WIDTH-1:0] oMemWrAddr;
    logic [DATA_WIDTH-1:0] oMemWrData;
    logic [7:0]            oMemWrLen;

    modport slave (
        input  iReqValid, iReqWr, iReqFunc3, iReqAddr, iReqWrData,
        input  iRespReady, iMemRdDataLoad,
        output oReqReady, oRespValid, oRespData, oRespErr,
        output oMemRdEn, oMemRdAddrLoad,
        output oMemWrEn, oMemWrAddr, oMemWrData, oMemWrLen
    );

    modport master (
        output iReqValid, iReqWr, iReqFunc3, iReqAddr, iReqWrData,
        output iRespReady, iMemRdDataLoad,
        input  oReqReady, oRespValid, oRespData, oRespErr,
        input  oMemRdEn, oMemRdAddrLoad,
        input  oMemWrEn, oMemWrAddr, oMemWrData, oMemWrLen
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu -- single-outstanding RISC-V load/store unit.
//
// Accepts one request at a time, checks size/alignment, performs a single
// 8-byte-aligned memory read (loads) or one write pulse (stores), and returns
// an extended load result or an error flag on the response channel.
//
// Ports:
//   iClock : clock, rising edge
//   iReset : asynchronous active-low reset
//   bus    : mem_lsu_if.slave (request, response, memory read/write buses)
module mem_lsu #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic       iClock,
    input  logic       iReset,
    mem_lsu_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR, RESP} state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  wr_q;
    logic [2:0]            func3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] resp_data_q;

    logic                  req_fire;
    logic                  req_illegal;
    logic [DATA_WIDTH-1:0] rd_shifted;

    // Size comes from funct3[1:0]; the unsigned variants share the size code.
    function automatic logic is_illegal(input logic wr, input logic [2:0] f3,
                                        input logic [2:0] alo);
        logic bad;
        bad = 1'b0;
        if (!wr && f3 == 3'b111) bad = 1'b1;
        if (wr && f3[2])         bad = 1'b1;
        case (f3[1:0])
            2'b01:   if (alo[0]   != 1'b0)  bad = 1'b1;
            2'b10:   if (alo[1:0] != 2'b00) bad = 1'b1;
            2'b11:   if (alo      != 3'b000) bad = 1'b1;
            default: ;
        endcase
        return bad;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] f3,
                                                     input logic [DATA_WIDTH-1:0] raw);
        case (f3)
            3'b000:  return {{(DATA_WIDTH-8){raw[7]}},   raw[7:0]};
            3'b001:  return {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
            3'b010:  return {{(DATA_WIDTH-32){raw[31]}}, raw[31:0]};
            3'b011:  return raw;
            3'b100:  return {{(DATA_WIDTH-8){1'b0}},  raw[7:0]};
            3'b101:  return {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
            3'b110:  return {{(DATA_WIDTH-32){1'b0}}, raw[31:0]};
            default: return '0;
        endcase
    endfunction

    assign req_fire    = bus.iReqValid & bus.oReqReady;
    assign req_illegal = is_illegal(bus.iReqWr, bus.iReqFunc3, bus.iReqAddr[2:0]);
    // Bring the addressed byte down to bit 0 of the returned dword.
    assign rd_shifted  = bus.iMemRdDataLoad >> {addr_q[2:0], 3'b000};

    // State register
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    if (req_illegal)     state_nxt = RESP;
                    else if (bus.iReqWr) state_nxt = WR;
                    else                 state_nxt = RD_REQ;
                end
            end
            RD_REQ:  state_nxt = RD_DATA;
            RD_DATA: state_nxt = RESP;
            WR:      state_nxt = RESP;
            RESP:    if (bus.iRespReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; enables vanish as soon as reset forces IDLE.
    // Ready is also gated by reset so nothing is accepted while it is held.
    always_comb begin
        bus.oReqReady  = (state == IDLE) & iReset;
        bus.oMemRdEn   = (state == RD_REQ);
        bus.oMemWrEn   = (state == WR);
        bus.oRespValid = (state == RESP);
    end

    assign bus.oMemRdAddrLoad = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    assign bus.oMemWrAddr     = addr_q;
    assign bus.oMemWrData     = wdata_q;
    assign bus.oMemWrLen      = 8'd1 << func3_q[1:0];
    assign bus.oRespData      = resp_data_q;
    assign bus.oRespErr       = err_q;

    // Request latch and response registers
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            wr_q        <= 1'b0;
            func3_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            resp_data_q <= '0;
        end else if (req_fire) begin
            wr_q        <= bus.iReqWr;
            func3_q     <= bus.iReqFunc3;
            addr_q      <= bus.iReqAddr;
            wdata_q     <= bus.iReqWrData;
            err_q       <= req_illegal;
            // Stores and errors respond with zero data.
            resp_data_q <= '0;
        end else if (state == RD_DATA && !wr_q) begin
            resp_data_q <= extend(func3_q, rd_shifted);
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu -- randomized self-checking bench for mem_lsu.
//
// A byte-array reference memory predicts every load result, error flag,
// latency and memory-write pulse; a separate environment memory answers the
// DUT's read port and absorbs its write pulses.
module tb_mem_lsu;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic iClock;
    logic iReset;

    mem_lsu_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    mem_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  ref_mem [256];
    logic [7:0]  env_mem [256];
    logic [63:0] rdata;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [63:0] rd_addr_seen;
    logic [63:0] wr_addr_seen;
    logic [63:0] wr_data_seen;
    logic [7:0]  wr_len_seen;
    logic [63:0] last_data;

    assign bus.iMemRdDataLoad = rdata;

    function automatic logic [63:0] env_word(input logic [7:0] off);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = env_mem[8'(off + 8'(i))];
        return w;
    endfunction

    // Environment memory: registered read, byte-lane write of oMemWrLen bytes.
    always @(posedge iClock) begin
        if (bus.oMemRdEn) begin
            rd_cnt       <= rd_cnt + 1;
            rd_addr_seen <= bus.oMemRdAddrLoad;
            rdata        <= env_word(bus.oMemRdAddrLoad[7:0]);
        end
        if (bus.oMemWrEn) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_seen <= bus.oMemWrAddr;
            wr_data_seen <= bus.oMemWrData;
            wr_len_seen  <= bus.oMemWrLen;
            for (int i = 0; i < 8; i++)
                if (i < int'(bus.oMemWrLen))
                    env_mem[8'(bus.oMemWrAddr[7:0] + 8'(i))] <= bus.oMemWrData[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One full transaction: predict, issue, measure latency, hold the
    // response for 'stall' cycles, then complete the handshake.
    task automatic do_req(input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] data, input int stall, input bit junk);
        int          size;
        bit          ill;
        logic [63:0] exp_data;
        int          exp_lat;
        int          rd0;
        int          wr0;
        int          cyc;
        logic [7:0]  off;

        size = 1 << f3[1:0];
        off  = addr[7:0];
        ill  = (!wr && f3 == 3'b111) || (wr && f3[2]) || ((addr % 64'(size)) != 0);
        exp_data = '0;
        if (!ill && !wr) begin
            for (int i = 0; i < size; i++)
                exp_data = exp_data | (64'(ref_mem[8'(off + 8'(i))]) << (8 * i));
            if (!f3[2] && size < 8 && exp_data[8*size-1])
                exp_data = exp_data | ~((64'd1 << (8 * size)) - 64'd1);
        end
        exp_lat = ill ? 1 : (wr ? 2 : 3);

        @(negedge iClock);
        chk("req_ready", bus.oReqReady, 1);
        bus.iReqValid  = 1'b1;
        bus.iReqWr     = wr;
        bus.iReqFunc3  = f3;
        bus.iReqAddr   = addr;
        bus.iReqWrData = data;
        bus.iRespReady = 1'b0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge iClock);

        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge iClock);
            if (junk) begin
                bus.iReqValid  = 1'($urandom_range(0, 1));
                bus.iReqWr     = 1'($urandom_range(0, 1));
                bus.iReqFunc3  = 3'($urandom_range(0, 7));
                bus.iReqAddr   = BASE + 64'($urandom_range(0, 255));
                bus.iReqWrData = {$urandom, $urandom};
            end else begin
                bus.iReqValid = 1'b0;
            end
            if (bus.oRespValid) begin
                cyc = c;
                break;
            end
        end
        if (cyc == 0) chk("resp_timeout", 0, 1);

        last_data = bus.oRespData;
        chk("latency", cyc, exp_lat);
        chk("resp_err", bus.oRespErr, ill);
        chk("resp_data", bus.oRespData, exp_data);
        chk("rd_pulses", rd_cnt - rd0, (!ill && !wr) ? 1 : 0);
        chk("wr_pulses", wr_cnt - wr0, (!ill && wr) ? 1 : 0);
        if (!ill && !wr) chk("rd_addr", rd_addr_seen, {addr[63:3], 3'b000});
        if (!ill && wr) begin
            chk("wr_addr", wr_addr_seen, addr);
            chk("wr_len",  wr_len_seen, size);
            chk("wr_data", wr_data_seen, data);
            for (int i = 0; i < size; i++) ref_mem[8'(off + 8'(i))] = data[8*i +: 8];
        end

        for (int s = 0; s < stall; s++) begin
            @(negedge iClock);
            chk("stall_valid", bus.oRespValid, 1);
            chk("stall_data",  bus.oRespData, exp_data);
            chk("stall_err",   bus.oRespErr, ill);
            chk("stall_ready", bus.oReqReady, 0);
        end

        bus.iRespReady = 1'b1;
        bus.iReqValid  = 1'b0;
        @(posedge iClock);
        @(negedge iClock);
        bus.iRespReady = 1'b0;
        chk("post_valid", bus.oRespValid, 0);
        chk("post_ready", bus.oReqReady, 1);
    endtask

    // Reset asserted while a store sits in its write cycle.
    task automatic reset_mid_write();
        int wr0;
        @(negedge iClock);
        chk("rst_req_ready", bus.oReqReady, 1);
        bus.iReqValid  = 1'b1;
        bus.iReqWr     = 1'b1;
        bus.iReqFunc3  = 3'b011;
        bus.iReqAddr   = BASE + 64'h10;
        bus.iReqWrData = 64'hA5A5_5A5A_0F0F_F0F0;
        bus.iRespReady = 1'b0;
        @(posedge iClock);
        @(negedge iClock);
        bus.iReqValid = 1'b0;
        chk("rst_wr_en_before", bus.oMemWrEn, 1);
        wr0 = wr_cnt;
        #2 iReset = 1'b0;
        #1;
        chk("rst_wr_en_async", bus.oMemWrEn, 0);
        chk("rst_ready_in_reset", bus.oReqReady, 0);
        chk("rst_valid_in_reset", bus.oRespValid, 0);
        chk("rst_data_in_reset", bus.oRespData, 0);
        @(negedge iClock);
        iReset = 1'b1;
        #1;
        chk("rst_ready_after", bus.oReqReady, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge iClock);
            chk("rst_no_resp", bus.oRespValid, 0);
        end
        chk("rst_no_write", wr_cnt - wr0, 0);
    endtask

    initial begin
        iReset         = 1'b0;
        bus.iReqValid  = 1'b0;
        bus.iReqWr     = 1'b0;
        bus.iReqFunc3  = '0;
        bus.iReqAddr   = '0;
        bus.iReqWrData = '0;
        bus.iRespReady = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        #12;
        chk("reset_ready",  bus.oReqReady, 0);
        chk("reset_valid",  bus.oRespValid, 0);
        chk("reset_err",    bus.oRespErr, 0);
        chk("reset_data",   bus.oRespData, 0);
        chk("reset_rd_en",  bus.oMemRdEn, 0);
        chk("reset_wr_en",  bus.oMemWrEn, 0);
        @(negedge iClock);
        iReset = 1'b1;
        #1;
        chk("reset_release_ready", bus.oReqReady, 1);

        // Fill the whole window with known dwords.
        for (int d = 0; d < 32; d++)
            do_req(1'b1, 3'b011, BASE + 64'(8 * d), {$urandom, $urandom}, 0, 1'b0);

        // Directed cases on the 0x80000000 dword.
        do_req(1'b1, 3'b011, BASE, 64'h1122_3344_5566_7788, 0, 1'b0);
        do_req(1'b0, 3'b000, BASE + 64'h7, 64'h0, 0, 1'b0);
        chk("lb_b7", last_data, 64'h0000_0000_0000_0011);
        do_req(1'b0, 3'b001, BASE + 64'h6, 64'h0, 0, 1'b0);
        chk("lh_b6", last_data, 64'h0000_0000_0000_1122);
        do_req(1'b1, 3'b000, BASE + 64'h5, 64'h99, 0, 1'b0);
        do_req(1'b0, 3'b100, BASE + 64'h5, 64'h0, 0, 1'b0);
        chk("lbu_b5", last_data, 64'h0000_0000_0000_0099);
        do_req(1'b0, 3'b000, BASE + 64'h5, 64'h0, 0, 1'b0);
        chk("lb_b5", last_data, 64'hFFFF_FFFF_FFFF_FF99);
        do_req(1'b1, 3'b010, BASE + 64'h104, 64'hDEAD_BEEF, 0, 1'b0);
        chk("sw_data", last_data, 64'h0);
        do_req(1'b0, 3'b010, BASE + 64'h2, 64'h0, 0, 1'b0);
        do_req(1'b1, 3'b100, BASE + 64'h8, 64'h1234, 0, 1'b0);
        do_req(1'b0, 3'b111, BASE + 64'h8, 64'h0, 0, 1'b0);
        do_req(1'b0, 3'b011, BASE, 64'h0, 5, 1'b1);

        reset_mid_write();

        for (int n = 0; n < 300; n++)
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   BASE + 64'($urandom_range(0, 255)), {$urandom, $urandom},
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
